// File: rtl/adc_mic_model.sv
// Serial 12-bit mic ADC slave model: 16-bit frames (4 leading zeros),
// MSB first, returning samples of a sine test tone; done after N frames.
//
// Ports:
//   clk_i    serial clock from master (rising edge logic)
//   reset_i  synchronous active-high reset
//   run_i    1 = tone, 0 = midscale silence with phase frozen
//   cs_i     active-low chip select framing one conversion
//   sd_o     registered serial data, MSB first
//   done_o   sticky level, high once NUM_SAMPLES frames completed
module adc_mic_model #(
  parameter int PERIOD      = 200,
  parameter int SAMPLE_US   = 20,
  parameter int NUM_SAMPLES = 1024
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic run_i,
  input  logic cs_i,
  output logic sd_o,
  output logic done_o
);

  localparam int STEP_I =
    (65536 * SAMPLE_US + PERIOD / 2) / PERIOD;
  localparam logic [15:0] PHASE_STEP = 16'(STEP_I);
  localparam int CW = $clog2(NUM_SAMPLES + 1);
  localparam logic [CW-1:0] NUM_C = CW'(NUM_SAMPLES);

  logic          cs_q, cs_d;
  logic          sd_q, sd_d;
  logic          done_q, done_d;
  logic [15:0]   phase_q, phase_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] conv_q, conv_d;
  logic [15:0]   shreg_q, shreg_d;

  // First quadrant of round(2047*sin(2*pi*k/64)), k = 0..16
  function automatic logic [10:0] quarter(input logic [4:0] k);
    logic [10:0] v;
    unique case (k)
      5'd0:    v = 11'd0;
      5'd1:    v = 11'd201;
      5'd2:    v = 11'd399;
      5'd3:    v = 11'd594;
      5'd4:    v = 11'd783;
      5'd5:    v = 11'd965;
      5'd6:    v = 11'd1137;
      5'd7:    v = 11'd1299;
      5'd8:    v = 11'd1447;
      5'd9:    v = 11'd1582;
      5'd10:   v = 11'd1702;
      5'd11:   v = 11'd1805;
      5'd12:   v = 11'd1891;
      5'd13:   v = 11'd1959;
      5'd14:   v = 11'd2008;
      5'd15:   v = 11'd2037;
      5'd16:   v = 11'd2047;
      default: v = 11'd0;
    endcase
    return v;
  endfunction

  logic [5:0]  idx;
  logic [4:0]  qk;
  logic [10:0] mag;
  logic [11:0] tone;
  logic [11:0] sample;
  logic [15:0] word;

  // Quarter-wave symmetry: odd quadrants mirror k, upper half negates
  assign idx    = phase_q[15:10];
  assign qk     = idx[4] ? (5'd16 - {1'b0, idx[3:0]})
                         : {1'b0, idx[3:0]};
  assign mag    = quarter(qk);
  assign tone   = idx[5] ? (12'd2048 - {1'b0, mag})
                         : (12'd2048 + {1'b0, mag});
  assign sample = run_i ? tone : 12'h800;
  assign word   = {4'b0000, sample};

  always_comb begin
    cs_d      = cs_i;
    sd_d      = 1'b0;
    done_d    = done_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    conv_d    = conv_q;
    shreg_d   = shreg_q;
    if (cs_i) begin
      bit_cnt_d = 5'd0;
      shreg_d   = 16'h0000;
    end else if (cs_q) begin
      sd_d      = word[15];
      shreg_d   = word << 1;
      bit_cnt_d = 5'd1;
    end else if (bit_cnt_q != 5'd0 && bit_cnt_q < 5'd16) begin
      sd_d      = shreg_q[15];
      shreg_d   = shreg_q << 1;
      bit_cnt_d = bit_cnt_q + 5'd1;
      // this edge drives the LSB: frame complete
      if (bit_cnt_q == 5'd15) begin
        if (conv_q != NUM_C)
          conv_d = conv_q + CW'(1);
        if (run_i)
          phase_d = phase_q + PHASE_STEP;
      end
    end
    if (conv_d == NUM_C)
      done_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cs_q      <= 1'b1;
      sd_q      <= 1'b0;
      done_q    <= 1'b0;
      phase_q   <= 16'h0000;
      bit_cnt_q <= 5'd0;
      conv_q    <= '0;
      shreg_q   <= 16'h0000;
    end else begin
      cs_q      <= cs_d;
      sd_q      <= sd_d;
      done_q    <= done_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      conv_q    <= conv_d;
      shreg_q   <= shreg_d;
    end
  end

  assign sd_o   = sd_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_adc_mic_model.sv
// Bench for adc_mic_model: random frames vs a sine reference,
// plus directed abort, run/hold, overlong-cs, reset and done cases.
module tb_adc_mic_model;

  localparam int NS   = 4;
  localparam int STEP = 6554;

  logic clk;
  logic reset;
  logic run;
  logic cs;
  logic sd;
  logic done;

  int total;
  int bad;

  int phase_m;
  int conv_m;

  logic [15:0] w;
  logic [15:0] wa;
  logic [15:0] hist [20];

  adc_mic_model #(
    .PERIOD      (200),
    .SAMPLE_US   (20),
    .NUM_SAMPLES (NS)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .run_i   (run),
    .cs_i    (cs),
    .sd_o    (sd),
    .done_o  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input bit r,
                                             input int ph);
    real a;
    int  v;
    if (!r) return 16'h0800;
    a = 2047.0 * $sin(2.0 * 3.14159265358979 *
                      real'(ph >> 10) / 64.0);
    if (a >= 0.0) v = int'($floor(a + 0.5));
    else          v = -int'($floor(-a + 0.5));
    return 16'(2048 + v);
  endfunction

  // Starts and ends at a negedge; run switches to rb after bit 8
  task automatic frame(input int ncyc, input bit ra,
                       input bit rb, output logic [15:0] wo);
    logic [15:0] exp;
    logic [15:0] got;
    exp = model_word(ra, phase_m);
    got = '0;
    run = ra;
    cs  = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i < 16) got = {got[14:0], sd};
      else check("tail", {31'd0, sd}, 32'd0);
      if (i == 15) begin
        if (conv_m < NS) conv_m++;
        if (rb) phase_m = (phase_m + STEP) & 32'hffff;
      end
      check("done", {31'd0, done}, {31'd0, conv_m >= NS});
      if (i == 7) run = rb;
    end
    if (ncyc >= 16) check("word", {16'd0, got}, {16'd0, exp});
    else check("part", {16'd0, got},
               {16'd0, exp >> (16 - ncyc)});
    wo = got;
    cs = 1'b1;
    @(negedge clk);
    check("idle", {31'd0, sd}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cs    = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sd", {31'd0, sd}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset   = 1'b0;
    phase_m = 0;
    conv_m  = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    run   = 1'b0;
    reset = 1'b1;
    cs    = 1'b1;
    do_reset();

    // first frame after reset: phase 0 -> midscale
    frame(16, 1'b1, 1'b1, w);
    check("first", {16'd0, w}, 32'h0800);
    hist[0] = w;

    // steady tone: 10-sample repetition, top nibble zero
    for (int k = 1; k < 20; k++) begin
      frame(16, 1'b1, 1'b1, w);
      hist[k] = w;
    end
    for (int k = 10; k < 20; k++) begin
      check("repeat", {16'd0, hist[k]}, {16'd0, hist[k-10]});
      check("nibble", {28'd0, hist[k][15:12]}, 32'd0);
    end

    // silence holds phase, then resume
    for (int k = 0; k < 3; k++) begin
      frame(16, 1'b0, 1'b0, w);
      check("silent", {16'd0, w}, 32'h0800);
    end
    frame(16, 1'b1, 1'b1, w);

    // abort after 8 bits, then full frame repeats same sample
    frame(8, 1'b1, 1'b1, wa);
    repeat (3) begin
      @(negedge clk);
      check("cs_hi", {31'd0, sd}, 32'd0);
    end
    frame(16, 1'b1, 1'b1, w);
    check("abort_eq", {24'd0, w[15:8]}, {24'd0, wa[7:0]});

    // cs held low past 16 bits: zeros, no second frame
    frame(24, 1'b1, 1'b1, w);

    // randomized frames with mid-frame run changes and aborts
    for (int k = 0; k < 30; k++) begin
      int n;
      if ($urandom_range(0, 4) == 0) n = $urandom_range(1, 15);
      else n = 16 + $urandom_range(0, 3);
      frame(n, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), w);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check("gap", {31'd0, sd}, 32'd0);
      end
    end

    // reset in the middle of a frame
    run = 1'b1;
    cs  = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_sd", {31'd0, sd}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    cs = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    phase_m = 0;
    conv_m  = 0;

    // done: aborted frame must not count
    frame(16, 1'b1, 1'b1, w);
    check("post_rst", {16'd0, w}, 32'h0800);
    frame(16, 1'b1, 1'b1, w);
    frame(10, 1'b1, 1'b1, w);
    frame(16, 1'b1, 1'b1, w);
    check("done_3", {31'd0, done}, 32'd0);
    frame(16, 1'b1, 1'b1, w);
    check("done_4", {31'd0, done}, 32'd1);
    frame(16, 1'b0, 1'b1, w);
    frame(18, 1'b1, 1'b0, w);
    check("done_hold", {31'd0, done}, 32'd1);
    do_reset();
    frame(16, 1'b1, 1'b1, w);
    check("final", {16'd0, w}, 32'h0800);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
